// File: rtl/m_merge_pipe_if.sv
// Handshake bundle for m_merge_pipe: input list pair, merged output list, and pipeline status.
interface m_merge_pipe_if #(
    parameter int WIDTH = 3,
    parameter int N     = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_desc;
    logic [2*N*WIDTH-1:0]   inba;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_desc;
    logic [2*N*WIDTH-1:0]   c;
    logic                   busy;

    modport master (
        output in_valid, in_desc, inba, out_ready,
        input  in_ready, out_valid, out_desc, c, busy
    );

    modport slave (
        input  in_valid, in_desc, inba, out_ready,
        output in_ready, out_valid, out_desc, c, busy
    );
endinterface

// File: rtl/m_merge_pipe.sv
// Pipelined Batcher odd-even merge of two ascending N-entry lists into one 2N-entry list,
// one register stage per comparator layer, global-stall back-pressure, optional reversed output.
module m_merge_pipe #(
    parameter int WIDTH = 3,
    parameter int N     = 32
) (
    input  logic          clk,
    input  logic          rst,
    m_merge_pipe_if.slave bus
);
    localparam int M      = 2 * N;
    localparam int DW     = M * WIDTH;
    localparam int LAYERS = $clog2(M);

    logic [LAYERS-1:0]          stage_valid;
    logic [LAYERS-1:0]          stage_desc;
    logic [LAYERS-1:0][DW-1:0]  stage_data;
    logic [LAYERS-1:0][DW-1:0]  layer_out;
    logic [DW-1:0]              last;
    logic                       adv;

    // The whole pipe moves or holds as one; bubbles are never squeezed out.
    assign adv = ~stage_valid[LAYERS-1] | bus.out_ready;

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        // Layer l compares entries K apart; below the first layer only odd multiples of K start a group.
        localparam int K  = N >> l;
        localparam int J0 = (K == N) ? 0 : K;

        logic [DW-1:0] lin;
        logic [DW-1:0] net;

        if (l == 0) begin : g_src_in
            assign lin = bus.inba;
        end else begin : g_src_stage
            assign lin = stage_data[l-1];
        end

        always_comb begin
            net = lin;
            for (int j = J0; j + K < M; j += 2 * K) begin
                for (int i = 0; i < K; i++) begin
                    // Swap only on strict less-than so equal keys keep their lower-index source on L.
                    if (lin[(i + j + K) * WIDTH +: WIDTH] < lin[(i + j) * WIDTH +: WIDTH]) begin
                        net[(i + j) * WIDTH +: WIDTH]     = lin[(i + j + K) * WIDTH +: WIDTH];
                        net[(i + j + K) * WIDTH +: WIDTH] = lin[(i + j) * WIDTH +: WIDTH];
                    end
                end
            end
        end

        assign layer_out[l] = net;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too, so c reads 0 (never X) before the first result arrives.
        if (rst) begin
            stage_valid <= '0;
            stage_desc  <= '0;
            stage_data  <= '0;
        end else if (adv) begin
            // NOTE: non-blocking assignments let every stage read its predecessor's old value in one edge.
            stage_valid[0] <= bus.in_valid;
            stage_desc[0]  <= bus.in_desc;
            for (int l = 1; l < LAYERS; l++) begin
                stage_valid[l] <= stage_valid[l-1];
                stage_desc[l]  <= stage_desc[l-1];
            end
            for (int l = 0; l < LAYERS; l++) begin
                stage_data[l] <= layer_out[l];
            end
        end
    end

    assign last = stage_data[LAYERS-1];

    // The network is always ascending; descending mode just mirrors the entry order on the way out.
    always_comb begin
        bus.c = last;
        if (stage_desc[LAYERS-1]) begin
            for (int k = 0; k < M; k++) begin
                bus.c[k * WIDTH +: WIDTH] = last[(M - 1 - k) * WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = stage_valid[LAYERS-1];
    assign bus.out_desc  = stage_desc[LAYERS-1];
    assign bus.busy      = |stage_valid;
endmodule
